// File: rtl/fetch_ifid_pkg.sv
// rv_pkg: fetch/decode shared state enum, NOP, opcode constants and IF/ID payload type
package rv_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP, S_HOLD} fetch_state_e;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        misalign;
  } ifid_t;
endpackage

// File: rtl/fetch_ifid_if.sv
// fetch_ifid_if: instruction memory request/response bus
// master = fetch unit (req, addr out; ready, rvalid, rdata in), slave = memory
interface fetch_ifid_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  modport master(output req, addr, input ready, rvalid, rdata);
  modport slave(input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_ifid_ifid_reg.sv
// ifid_reg: IF/ID pipeline register with load, stall hold and flush
// i_load writes i_data and sets valid; i_stall holds a live entry; i_flush or an accept without load clears valid
module ifid_reg import rv_pkg::*; (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_load,
  input  logic  i_flush,
  input  logic  i_stall,
  input  ifid_t i_data,
  output logic  o_valid,
  output ifid_t o_data
);
  logic  r_valid;
  ifid_t r_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= {NOP, 32'd0, 32'd0, 1'b0};
    end else begin
      r_valid <= i_load | (r_valid & i_stall & ~i_flush);
      if (i_load) r_data <= i_data;
    end
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/fetch_ifid.sv
// fetch_ifid: single-outstanding instruction fetch FSM feeding the IF/ID register
// ports: clk, rst_n (async low); imem (fetch_ifid_if.master); i_redirect_valid/i_redirect_pc; i_id_stall;
// o_id_valid/o_id_instr/o_id_pc/o_id_pc4; o_id_misalign only with FETCH_MISALIGN_TRAP_EN
module fetch_ifid import rv_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_ifid_if.master        imem,
  input  logic                i_redirect_valid,
  input  logic [31:0]         i_redirect_pc,
  input  logic                i_id_stall,
  output logic                o_id_valid,
  output logic [31:0]         o_id_instr,
  output logic [31:0]         o_id_pc,
  output logic [31:0]         o_id_pc4
`ifdef FETCH_MISALIGN_TRAP_EN
  ,output logic               o_id_misalign
`endif
);
  fetch_state_e r_state, w_next;
  logic [31:0]  r_pc, r_hold, w_redir_pc, w_pc4;
  logic         w_free, w_acc, w_fill, w_unhold, w_mis, w_block;
  ifid_t        w_in, w_out;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_mis;
  assign w_redir_pc = i_redirect_pc;
  assign w_mis      = i_redirect_valid & |i_redirect_pc[1:0];
  // a misaligned target parks the fetcher in REQ with no request until the next redirect
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_mis <= 1'b0;
    else if (i_redirect_valid) r_mis <= w_mis;
  assign w_block       = r_mis;
  assign o_id_misalign = w_out.misalign;
`else
  logic w_unused;
  assign w_redir_pc = {i_redirect_pc[31:2], 2'b00};
  assign w_mis      = 1'b0;
  assign w_block    = 1'b0;
  assign w_unused   = ^{i_redirect_pc[1:0], w_out.misalign};
`endif
  assign w_free    = !o_id_valid || !i_id_stall;
  assign imem.req  = (r_state == S_REQ) && !w_block;
  assign imem.addr = r_pc;
  assign w_acc     = imem.req && imem.ready;
  assign w_fill    = (r_state == S_WAIT) && imem.rvalid && w_free && !i_redirect_valid;
  assign w_unhold  = (r_state == S_HOLD) && !i_id_stall && !i_redirect_valid;
  assign w_pc4     = r_pc + 32'd4;
  assign w_in      = w_mis ? {NOP, w_redir_pc, w_redir_pc + 32'd4, 1'b1}
                           : {w_fill ? imem.rdata : r_hold, r_pc, w_pc4, 1'b0};
  // a redirect while a request is in flight must drain its response in DROP
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_REQ;
      S_REQ:   w_next = w_acc ? (i_redirect_valid ? S_DROP : S_WAIT) : S_REQ;
      S_WAIT:  w_next = imem.rvalid ? ((i_redirect_valid || w_free) ? S_REQ : S_HOLD)
                                    : (i_redirect_valid ? S_DROP : S_WAIT);
      S_DROP:  w_next = imem.rvalid ? S_REQ : S_DROP;
      S_HOLD:  w_next = (i_redirect_valid || !i_id_stall) ? S_REQ : S_HOLD;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_hold  <= '0;
    end else begin
      r_state <= w_next;
      r_pc    <= i_redirect_valid ? w_redir_pc : (w_fill || w_unhold) ? w_pc4 : r_pc;
      r_hold  <= i_redirect_valid ? '0
               : (r_state == S_WAIT && imem.rvalid && !w_free) ? imem.rdata : r_hold;
    end
  ifid_reg u_ifid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_fill || w_unhold || w_mis),
    .i_flush (i_redirect_valid),
    .i_stall (i_id_stall),
    .i_data  (w_in),
    .o_valid (o_id_valid),
    .o_data  (w_out)
  );
  assign o_id_instr = w_out.instr;
  assign o_id_pc    = w_out.pc;
  assign o_id_pc4   = w_out.pc4;
endmodule

// File: tb/tb_fetch_ifid.sv
// tb_fetch_ifid: table, directed and randomized checks of fetch_ifid
module tb_fetch_ifid;
  import rv_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redir = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] rpc = '0;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_pc4;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        id_mis;
`endif
  int errs = 0;
  int checks = 0;
  fetch_ifid_if imem();
  fetch_ifid dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem             (imem),
    .i_redirect_valid (redir),
    .i_redirect_pc    (rpc),
    .i_id_stall       (stall),
    .o_id_valid       (id_valid),
    .o_id_instr       (id_instr),
    .o_id_pc          (id_pc),
    .o_id_pc4         (id_pc4)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,.o_id_misalign   (id_mis)
`endif
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic        ready, rvalid, redir, stall;
    logic [31:0] rdata, rpc;
    logic        req;
    logic [31:0] addr;
    logic        val;
    logic [31:0] instr, pc, pc4;
  } vec_t;
  vec_t vt[15];
  function automatic vec_t mk(input logic [3:0] in, input logic [31:0] rdata, input logic [31:0] rp,
                              input logic req, input logic [31:0] addr, input logic val,
                              input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc4);
    return {in, rdata, rp, req, addr, val, instr, pc, pc4};
  endfunction
  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction
  function automatic logic [129:0] obs();
    return {imem.req, imem.addr, id_valid, id_instr, id_pc, id_pc4};
  endfunction
  task automatic chk(input string name, input logic [129:0] act, input logic [129:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  logic [31:0] exp_pc, paddr, last_addr;
  logic        pend, hold_addr;
  int          cnt, consumed;
  initial begin
    // rows: {ready,rvalid,redir,stall}, rdata, redirect_pc -> req, addr, id_valid, id_instr, id_pc, id_pc4
    vt[0]  = mk(4'b1000, 32'h0,         32'h0,   1'b0, 32'h0,   1'b0, NOP,          32'h0, 32'h0);
    vt[1]  = mk(4'b1000, 32'h0,         32'h0,   1'b1, 32'h0,   1'b0, NOP,          32'h0, 32'h0);
    vt[2]  = mk(4'b0100, 32'h13,        32'h0,   1'b0, 32'h0,   1'b0, NOP,          32'h0, 32'h0);
    vt[3]  = mk(4'b0001, 32'h0,         32'h0,   1'b1, 32'h4,   1'b1, 32'h13,       32'h0, 32'h4);
    vt[4]  = mk(4'b1001, 32'h0,         32'h0,   1'b1, 32'h4,   1'b1, 32'h13,       32'h0, 32'h4);
    vt[5]  = mk(4'b0101, 32'h00A00093,  32'h0,   1'b0, 32'h4,   1'b1, 32'h13,       32'h0, 32'h4);
    vt[6]  = mk(4'b0001, 32'h0,         32'h0,   1'b0, 32'h4,   1'b1, 32'h13,       32'h0, 32'h4);
    vt[7]  = mk(4'b0000, 32'h0,         32'h0,   1'b0, 32'h4,   1'b1, 32'h13,       32'h0, 32'h4);
    vt[8]  = mk(4'b1001, 32'h0,         32'h0,   1'b1, 32'h8,   1'b1, 32'h00A00093, 32'h4, 32'h8);
    vt[9]  = mk(4'b0011, 32'h0,         32'h100, 1'b0, 32'h8,   1'b1, 32'h00A00093, 32'h4, 32'h8);
    vt[10] = mk(4'b0100, 32'hDEADBEEF,  32'h0,   1'b0, 32'h100, 1'b0, 32'h00A00093, 32'h4, 32'h8);
    vt[11] = mk(4'b1000, 32'h0,         32'h0,   1'b1, 32'h100, 1'b0, 32'h00A00093, 32'h4, 32'h8);
    vt[12] = mk(4'b0110, 32'h11111111,  32'h200, 1'b0, 32'h100, 1'b0, 32'h00A00093, 32'h4, 32'h8);
    vt[13] = mk(4'b0000, 32'h0,         32'h0,   1'b1, 32'h200, 1'b0, 32'h00A00093, 32'h4, 32'h8);
    vt[14] = mk(4'b0000, 32'h0,         32'h0,   1'b1, 32'h200, 1'b0, 32'h00A00093, 32'h4, 32'h8);
    imem.ready = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
    repeat (2) @(negedge clk);
    chk("reset", obs(), {1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0});
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("row%0d", k), obs(), {vt[k].req, vt[k].addr, vt[k].val, vt[k].instr, vt[k].pc, vt[k].pc4});
      {imem.ready, imem.rvalid, redir, stall} = {vt[k].ready, vt[k].rvalid, vt[k].redir, vt[k].stall};
      imem.rdata = vt[k].rdata;
      rpc = vt[k].rpc;
      @(negedge clk);
    end
    // PC wrap at the top of the address space
    redir = 1'b1; rpc = 32'hFFFF_FFFC; @(negedge clk); redir = 1'b0;
    chk("wrap_addr", obs(), {1'b1, 32'hFFFF_FFFC, 1'b0, 32'h00A00093, 32'h4, 32'h8});
    imem.ready = 1'b1; @(negedge clk);
    imem.ready = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'h0000_0513; @(negedge clk);
    imem.rvalid = 1'b0;
    chk("wrap_next", obs(), {1'b1, 32'h0, 1'b1, 32'h0000_0513, 32'hFFFF_FFFC, 32'h0});
`ifdef FETCH_MISALIGN_TRAP_EN
    redir = 1'b1; rpc = 32'h102; @(negedge clk); redir = 1'b0;
    chk("mis_trap", obs(), {1'b0, 32'h102, 1'b1, NOP, 32'h102, 32'h106});
    chk32("mis_flag", {31'd0, id_mis}, 32'd1);
    @(negedge clk);
    chk("mis_noreq", obs(), {1'b0, 32'h102, 1'b0, NOP, 32'h102, 32'h106});
    redir = 1'b1; rpc = 32'h300; @(negedge clk); redir = 1'b0;
    chk("mis_exit", obs(), {1'b1, 32'h300, 1'b0, NOP, 32'h102, 32'h106});
`else
    redir = 1'b1; rpc = 32'h103; @(negedge clk); redir = 1'b0;
    chk("align_force", obs(), {1'b1, 32'h100, 1'b0, 32'h0000_0513, 32'hFFFF_FFFC, 32'h0});
`endif
    // reset pulsed while a request is outstanding
    redir = 1'b1; rpc = 32'h40; @(negedge clk); redir = 1'b0;
    imem.ready = 1'b1; @(negedge clk);
    imem.ready = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'h700; stall = 1'b1; @(negedge clk);
    imem.rvalid = 1'b0; imem.ready = 1'b1; @(negedge clk);
    imem.ready = 1'b0;
    chk("pre_reset", obs(), {1'b0, 32'h44, 1'b1, 32'h700, 32'h40, 32'h44});
    #2 rst_n = 1'b0;
    #1 chk("async_reset", obs(), {1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0});
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'hBAD0_0BAD;
    repeat (2) @(negedge clk);
    imem.rvalid = 1'b0;
    chk("stale_ignored", obs(), {1'b1, 32'h0, 1'b0, NOP, 32'h0, 32'h0});
    imem.ready = 1'b1; @(negedge clk);
    imem.ready = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'h13; @(negedge clk);
    imem.rvalid = 1'b0;
    chk("post_reset", obs(), {1'b1, 32'h4, 1'b1, 32'h13, 32'h0, 32'h4});
    // randomized run: decode must see the architectural instruction stream in order
    rst_n = 1'b0; stall = 1'b0; redir = 1'b0; imem.ready = 1'b0; imem.rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 32'h0; pend = 1'b0; cnt = 0; consumed = 0; hold_addr = 1'b0; last_addr = '0; paddr = '0;
    for (int c = 0; c < 3000; c++) begin
      imem.rvalid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          imem.rvalid = 1'b1; imem.rdata = f(paddr); pend = 1'b0;
        end else cnt--;
      end
      stall = ($urandom_range(0, 2) == 0);
      redir = ($urandom_range(0, 24) == 0);
      rpc = $urandom & 32'hFFFF_FFFC;
      imem.ready = 1'($urandom_range(0, 1));
      if (imem.req) begin
        if (hold_addr) chk32("addr_stable", imem.addr, last_addr);
        if (imem.ready) begin
          pend = 1'b1; paddr = imem.addr; cnt = $urandom_range(0, 3);
        end
      end
      hold_addr = imem.req && !imem.ready && !redir;
      last_addr = imem.addr;
      if (id_valid && !stall && !redir) begin
        chk32("rand_pc", id_pc, exp_pc);
        chk32("rand_instr", id_instr, f(exp_pc));
        chk32("rand_pc4", id_pc4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (redir) exp_pc = rpc;
      @(negedge clk);
    end
    chk32("progress", {31'd0, consumed > 100}, 32'd1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
